// File: rtl/magcomp_pkg.sv
// Shared types and helpers for the pipelined magnitude comparator.
//   cmp_flags_t       - cascaded compare result {eq, gt, lt}
//   CMP_RESET_CASCADE - cascade seed for the most significant slice ("equal so far")
//   signed_msb()      - MSB remap that turns a two's-complement compare into an
//                       unsigned (offset-binary) one
package magcomp_pkg;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_flags_t;

    localparam cmp_flags_t CMP_RESET_CASCADE = '{eq: 1'b1, gt: 1'b0, lt: 1'b0};

    // Inverting the sign bit maps -2^(N-1)..2^(N-1)-1 monotonically onto 0..2^N-1.
    function automatic logic signed_msb(input logic msb, input logic is_signed);
        return msb ^ is_signed;
    endfunction

endpackage

// File: rtl/magcomp_if.sv
// Operand / result stream bundle for magcomp_pipe.
//   in_valid/in_ready   - operand handshake (in_a, in_b, in_signed payload)
//   out_valid/out_ready - result handshake (out_equal, out_a_great, out_b_great payload)
// master: the side that supplies operands and consumes results.
// slave : the comparator itself.
interface magcomp_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic             out_equal;
    logic             out_a_great;
    logic             out_b_great;

    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, out_equal, out_a_great, out_b_great
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, out_equal, out_a_great, out_b_great
    );
endinterface

// File: rtl/magcomp_slice.sv
// Combinational SLICE-bit magnitude compare with cascade in/out.
//   slice_a, slice_b - operand slices for this stage
//   cascade_in       - verdict from the more significant slices
//   cascade_out      - verdict including this slice
// A verdict already decided upstream (gt or lt) passes through untouched; only an
// "equal so far" cascade lets this slice decide.
module magcomp_slice
    import magcomp_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] slice_a,
    input  logic [SLICE-1:0] slice_b,
    input  cmp_flags_t       cascade_in,
    output cmp_flags_t       cascade_out
);

    assign cascade_out.gt = cascade_in.gt | (cascade_in.eq & (slice_a > slice_b));
    assign cascade_out.lt = cascade_in.lt | (cascade_in.eq & (slice_a < slice_b));
    assign cascade_out.eq = cascade_in.eq & (slice_a == slice_b);

endmodule

// File: rtl/magcomp_pipe.sv
// Pipelined WIDTH-bit magnitude comparator, SLICE bits per stage, MSB slice first.
//   clk - rising-edge clock
//   rst - synchronous active-high reset; drops every in-flight transaction
//   bus - magcomp_if slave: operand stream in, {equal, a_great, b_great} stream out
// One register stage per slice, elastic valid/ready chain, one result per cycle at
// full throughput, latency WIDTH/SLICE cycles.
module magcomp_pipe
    import magcomp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic      clk,
    input  logic      rst,
    magcomp_if.slave  bus
);

    localparam int STAGES = WIDTH / SLICE;

    // ready[k]: stage k may load this cycle; ready[STAGES] is the downstream sink.
    logic [STAGES:0]  ready;
    logic [WIDTH-1:0] in0_a;
    logic [WIDTH-1:0] in0_b;

    // Signed mode only touches the operand MSBs, ahead of stage 0; every later
    // stage is a plain unsigned slice compare.
    always_comb begin
        in0_a            = bus.in_a;
        in0_b            = bus.in_b;
        in0_a[WIDTH-1]   = signed_msb(bus.in_a[WIDTH-1], bus.in_signed);
        in0_b[WIDTH-1]   = signed_msb(bus.in_b[WIDTH-1], bus.in_signed);
    end

    assign ready[STAGES] = bus.out_ready;
    assign bus.in_ready  = ready[0];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // Operand bits still to be compared when entering this stage.
            localparam int IN_W = WIDTH - gi * SLICE;

            logic [IN_W-1:0] op_a;
            logic [IN_W-1:0] op_b;
            logic            v_in;
            cmp_flags_t      c_in;
            cmp_flags_t      c_out;
            logic            valid_reg;
            cmp_flags_t      flags_reg;

            if (gi == 0) begin : g_first
                assign op_a = in0_a;
                assign op_b = in0_b;
                assign v_in = bus.in_valid;
                assign c_in = CMP_RESET_CASCADE;
            end else begin : g_next
                assign op_a = g_stage[gi-1].g_rem.rem_a_reg;
                assign op_b = g_stage[gi-1].g_rem.rem_b_reg;
                assign v_in = g_stage[gi-1].valid_reg;
                assign c_in = g_stage[gi-1].flags_reg;
            end

            magcomp_slice #(
                .SLICE (SLICE)
            ) u_slice (
                .slice_a     (op_a[IN_W-1 -: SLICE]),
                .slice_b     (op_b[IN_W-1 -: SLICE]),
                .cascade_in  (c_in),
                .cascade_out (c_out)
            );

            // Load when empty or when the occupant leaves this same cycle.
            assign ready[gi] = !valid_reg | ready[gi+1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    flags_reg <= '0;
                end else if (ready[gi]) begin
                    valid_reg <= v_in;
                    // Payload only changes with a real transaction, so a held or
                    // idle output stays quiet.
                    if (v_in) begin
                        flags_reg <= c_out;
                    end
                end
            end

            // The lower, not-yet-compared bits travel with the flags; the last
            // stage has nothing left to carry.
            if (IN_W > SLICE) begin : g_rem
                logic [IN_W-SLICE-1:0] rem_a_reg;
                logic [IN_W-SLICE-1:0] rem_b_reg;

                always_ff @(posedge clk) begin
                    if (ready[gi] && v_in) begin
                        rem_a_reg <= op_a[IN_W-SLICE-1:0];
                        rem_b_reg <= op_b[IN_W-SLICE-1:0];
                    end
                end
            end
        end
    endgenerate

    assign bus.out_valid   = g_stage[STAGES-1].valid_reg;
    assign bus.out_equal   = g_stage[STAGES-1].flags_reg.eq;
    assign bus.out_a_great = g_stage[STAGES-1].flags_reg.gt;
    assign bus.out_b_great = g_stage[STAGES-1].flags_reg.lt;

endmodule

// File: tb/tb_magcomp_pipe.sv
// Self-checking bench for magcomp_pipe at three widths (16/4, 8/4, 4/4).
// Expected results come from integer arithmetic on the operands; a FIFO of
// expected results per instance checks ordering, latency and flow control.
module tb_magcomp_pipe;

    localparam int LAT16 = 4;
    localparam int LAT8  = 2;
    localparam int LAT4  = 1;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst8 = 1'b1;
    logic rst4 = 1'b1;

    always #5 clk = ~clk;

    magcomp_if #(.WIDTH(16)) m16 ();
    magcomp_if #(.WIDTH(8))  m8  ();
    magcomp_if #(.WIDTH(4))  m4  ();

    magcomp_pipe #(.WIDTH(16), .SLICE(4)) dut16 (.clk(clk), .rst(rst),  .bus(m16));
    magcomp_pipe #(.WIDTH(8),  .SLICE(4)) dut8  (.clk(clk), .rst(rst8), .bus(m8));
    magcomp_pipe #(.WIDTH(4),  .SLICE(4)) dut4  (.clk(clk), .rst(rst4), .bus(m4));

    typedef struct {
        int          cyc;
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [2:0]  f;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    exp_t q4[$];

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int xfer16   = 0;
    bit done8    = 1'b0;
    bit done4    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: {eq, gt, lt} from the operands' integer values.
    function automatic logic [2:0] ref_cmp(input logic [15:0] a, input logic [15:0] b,
                                           input logic s, input int w);
        longint span;
        longint va;
        longint vb;
        span = longint'(1) << w;
        va   = longint'(a) & (span - 1);
        vb   = longint'(b) & (span - 1);
        if (s && va >= span / 2) va = va - span;
        if (s && vb >= span / 2) vb = vb - span;
        return {va == vb, va > vb, va < vb};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors (sample mid-cycle, away from posedge) -------------
    always @(negedge clk) begin
        logic [2:0] got;
        got = {m16.out_equal, m16.out_a_great, m16.out_b_great};
        if (rst) begin
            q16.delete();
        end else begin
            chk("in_ready16", m16.in_ready, (q16.size() < LAT16) || m16.out_ready);
            if (q16.size() == 0) begin
                chk("idle_valid16", m16.out_valid, 0);
            end else if (cyc < q16[0].cyc + LAT16) begin
                chk("early_valid16", m16.out_valid, 0);
            end else begin
                chk("due_valid16", m16.out_valid, 1);
                if (m16.out_valid) begin
                    chk("result16", got, q16[0].f);
                    if (m16.out_ready) begin
                        $display("xfer16 a=%04h b=%04h s=%0d flags(eq,gt,lt)=%03b",
                                 q16[0].a, q16[0].b, q16[0].s, got);
                        xfer16++;
                        void'(q16.pop_front());
                    end
                end
            end
            if (m16.in_valid && m16.in_ready)
                q16.push_back('{cyc: cyc, a: m16.in_a, b: m16.in_b, s: m16.in_signed,
                                f: ref_cmp(m16.in_a, m16.in_b, m16.in_signed, 16)});
        end
    end

    always @(negedge clk) begin
        if (rst8) begin
            q8.delete();
        end else begin
            chk("in_ready8", m8.in_ready, 1);
            if (q8.size() == 0) begin
                chk("idle_valid8", m8.out_valid, 0);
            end else if (cyc < q8[0].cyc + LAT8) begin
                chk("early_valid8", m8.out_valid, 0);
            end else begin
                chk("due_valid8", m8.out_valid, 1);
                if (m8.out_valid) begin
                    chk("result8", {m8.out_equal, m8.out_a_great, m8.out_b_great}, q8[0].f);
                    void'(q8.pop_front());
                end
            end
            if (m8.in_valid && m8.in_ready)
                q8.push_back('{cyc: cyc, a: {8'h00, m8.in_a}, b: {8'h00, m8.in_b},
                               s: m8.in_signed,
                               f: ref_cmp({8'h00, m8.in_a}, {8'h00, m8.in_b}, m8.in_signed, 8)});
        end
    end

    always @(negedge clk) begin
        if (rst4) begin
            q4.delete();
        end else begin
            chk("in_ready4", m4.in_ready, 1);
            if (q4.size() == 0) begin
                chk("idle_valid4", m4.out_valid, 0);
            end else if (cyc < q4[0].cyc + LAT4) begin
                chk("early_valid4", m4.out_valid, 0);
            end else begin
                chk("due_valid4", m4.out_valid, 1);
                if (m4.out_valid) begin
                    chk("result4", {m4.out_equal, m4.out_a_great, m4.out_b_great}, q4[0].f);
                    void'(q4.pop_front());
                end
            end
            if (m4.in_valid && m4.in_ready)
                q4.push_back('{cyc: cyc, a: {12'h000, m4.in_a}, b: {12'h000, m4.in_b},
                               s: m4.in_signed,
                               f: ref_cmp({12'h000, m4.in_a}, {12'h000, m4.in_b}, m4.in_signed, 4)});
        end
    end

    // ---------------- 16-bit stimulus ----------------
    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic s);
        m16.in_valid  = 1'b1;
        m16.in_a      = a;
        m16.in_b      = b;
        m16.in_signed = s;
    endtask

    function automatic logic [15:0] rand_b(input logic [15:0] a);
        // Half the time differ from A in a single bit so deep stages decide.
        if ($urandom_range(0, 1) == 1)
            return a ^ (16'h0001 << $urandom_range(0, 15));
        return 16'($urandom);
    endfunction

    task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic s, input logic [2:0] exp);
        drive(a, b, s);
        tick();
        m16.in_valid = 1'b0;
        repeat (LAT16 - 2) tick();
        chk({name, "_early"}, m16.out_valid, 0);
        tick();
        chk({name, "_valid"}, m16.out_valid, 1);
        chk(name, {m16.out_equal, m16.out_a_great, m16.out_b_great}, exp);
        tick();
    endtask

    task automatic drain16();
        m16.in_valid  = 1'b0;
        m16.out_ready = 1'b1;
        for (int k = 0; k < 40 && q16.size() != 0; k++) tick();
        chk("drain16", q16.size(), 0);
    endtask

    initial begin
        logic [15:0] pa [6];
        logic [15:0] pb [6];
        int          x0;
        logic [15:0] ra;

        m16.in_valid  = 1'b0;
        m16.in_a      = '0;
        m16.in_b      = '0;
        m16.in_signed = 1'b0;
        m16.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        chk("reset_valid", m16.out_valid, 0);
        chk("reset_flags", {m16.out_equal, m16.out_a_great, m16.out_b_great}, 3'b000);
        chk("reset_ready", m16.in_ready, 1);

        directed("eq_1234",      16'h1234, 16'h1234, 1'b0, 3'b100);
        directed("agt_1235",     16'h1235, 16'h1234, 1'b0, 3'b010);
        directed("blt_0fff",     16'h0FFF, 16'h1000, 1'b0, 3'b001);
        directed("s_m1_vs_1",    16'hFFFF, 16'h0001, 1'b1, 3'b001);
        directed("u_ffff_vs_1",  16'hFFFF, 16'h0001, 1'b0, 3'b010);
        directed("s_8000_7fff",  16'h8000, 16'h7FFF, 1'b1, 3'b001);
        directed("u_8000_7fff",  16'h8000, 16'h7FFF, 1'b0, 3'b010);
        directed("s_eq_8000",    16'h8000, 16'h8000, 1'b1, 3'b100);

        // Throughput: 100 back-to-back pairs, ready must never drop.
        x0 = xfer16;
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            drive(ra, rand_b(ra), 1'($urandom_range(0, 1)));
            chk("tput_ready", m16.in_ready, 1);
            tick();
        end
        drain16();
        chk("tput_count", xfer16 - x0, 100);

        // Backpressure: 4 fit, the 5th is refused, output frozen on the oldest.
        for (int i = 0; i < 6; i++) begin
            pa[i] = 16'($urandom);
            pb[i] = rand_b(pa[i]);
        end
        m16.out_ready = 1'b0;
        x0 = xfer16;
        for (int i = 0; i < 4; i++) begin
            drive(pa[i], pb[i], 1'b0);
            chk("bp_accept", m16.in_ready, 1);
            tick();
        end
        drive(pa[4], pb[4], 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("bp_full", m16.in_ready, 0);
            chk("bp_valid", m16.out_valid, 1);
            chk("bp_frozen", {m16.out_equal, m16.out_a_great, m16.out_b_great},
                ref_cmp(pa[0], pb[0], 1'b0, 16));
            tick();
        end
        m16.out_ready = 1'b1;
        tick();
        drive(pa[5], pb[5], 1'b0);
        tick();
        drain16();
        chk("bp_count", xfer16 - x0, 6);

        // Reset with three transactions in flight.
        x0 = xfer16;
        for (int i = 0; i < 3; i++) begin
            ra = 16'($urandom);
            drive(ra, rand_b(ra), 1'b0);
            tick();
        end
        m16.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid", m16.out_valid, 0);
        chk("rst_flags", {m16.out_equal, m16.out_a_great, m16.out_b_great}, 3'b000);
        chk("rst_ready", m16.in_ready, 1);
        repeat (8) tick();
        chk("rst_dropped", xfer16 - x0, 0);

        // Random valid/ready mix.
        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            m16.in_valid  = 1'($urandom_range(0, 1));
            m16.in_a      = ra;
            m16.in_b      = rand_b(ra);
            m16.in_signed = 1'($urandom_range(0, 1));
            m16.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain16();

        for (int k = 0; k < 80000 && !(done8 && done4); k++) tick();
        chk("sweep_done", {30'd0, done8, done4}, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- 8-bit: exhaustive unsigned, like the legacy comparator -----
    initial begin
        m8.in_valid  = 1'b0;
        m8.in_a      = '0;
        m8.in_b      = '0;
        m8.in_signed = 1'b0;
        m8.out_ready = 1'b1;
        rst8 = 1'b1;
        repeat (2) tick();
        rst8 = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            m8.in_valid = 1'b1;
            m8.in_a     = 8'(i >> 8);
            m8.in_b     = 8'(i);
            tick();
        end
        m8.in_valid = 1'b0;
        repeat (LAT8 + 2) tick();
        chk("drain8", q8.size(), 0);
        done8 = 1'b1;
    end

    // ---------------- 4-bit: single stage, random signed/unsigned ----------------
    initial begin
        m4.in_valid  = 1'b0;
        m4.in_a      = '0;
        m4.in_b      = '0;
        m4.in_signed = 1'b0;
        m4.out_ready = 1'b1;
        rst4 = 1'b1;
        repeat (2) tick();
        rst4 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            m4.in_valid  = ($urandom_range(0, 3) != 0);
            m4.in_a      = 4'($urandom);
            m4.in_b      = 4'($urandom);
            m4.in_signed = 1'($urandom_range(0, 1));
            tick();
        end
        m4.in_valid = 1'b0;
        repeat (LAT4 + 2) tick();
        chk("drain4", q4.size(), 0);
        done4 = 1'b1;
    end

endmodule
